// File: rtl/alu_ctl_unit_pkg.sv
// -----------------------------------------------------------------------------
// alu_ctl_unit_pkg
// Shared definitions for the execution-stage blocks (control unit, ALU,
// shifter, MULTU/HiLo datapath):
//   - R-type funct-code constants
//   - FSM state encoding for the multiply sequencer
//   - default multiply length
//   - helper that classifies plain ALU funct codes
// -----------------------------------------------------------------------------
package alu_ctl_unit_pkg;

  // R-type funct codes understood by the execution stage
  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_SLT   = 6'd42;
  localparam logic [5:0] FN_SRL   = 6'd2;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MFLO  = 6'd18;

  // The shift-add multiplier needs one cycle per multiplier bit
  localparam int DEF_MUL_CYCLES = 32;

  // Multiply sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DONE = 2'd2
  } ctlState_e;

  // True for funct codes that are executed by the 32-bit ALU
  function automatic logic isAluCode(input logic [5:0] code);
    return (code == FN_AND) || (code == FN_OR) || (code == FN_ADD) ||
           (code == FN_SUB) || (code == FN_SLT);
  endfunction

endpackage

// File: rtl/alu_ctl_unit_counter.sv
// -----------------------------------------------------------------------------
// mul_cycle_counter
// Cycle counter for the shift-add MULTU. It counts 0..MUL_CYCLES-1 while the
// multiply is running and flags the terminal count so the sequencer can leave
// its MULT state before the counter could ever wrap.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-high reset
//   start  in   held high for every cycle the multiply is running
//   cnt    out  current multiply cycle (0 outside a multiply)
//   last   out  high in the final multiply cycle
// -----------------------------------------------------------------------------
module mul_cycle_counter
  import alu_ctl_unit_pkg::*;
#(
  parameter int MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int CNT_W      = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_CYCLES - 1);

  // Terminal count is only meaningful while the multiply is running
  assign last = start && (cnt == LAST_CNT);

  // Count while running; clearing at the terminal count means the counter
  // already reads zero in the cycle the result becomes valid and stays there
  // until the next multiply begins
  always_ff @(posedge clk) begin
    if (reset || !start || last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_ctl_unit.sv
// -----------------------------------------------------------------------------
// alu_ctl_unit
// Funct-code control stage in front of the ALU, barrel shifter and MULTU/HiLo
// datapath. Decodes the R-type funct code into per-unit codes, sequences the
// multi-cycle MULTU and selects which unit drives the result mux.
// Ports:
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-high reset
//   Signal         in   6-bit funct code from decode
//   SignaltoALU    out  code for the ALU (0 = idle)
//   SignaltoSHT    out  code for the shifter (0 = idle)
//   SignaltoMULTU  out  code for the multiplier (25 while multiplying)
//   SignaltoMUX    out  result-mux select (ALU / SRL / MFHI / MFLO code)
//   busy           out  multiply in progress
//   done           out  one-cycle pulse, Hi/Lo now hold the product
//   stall          out  MFHI/MFLO presented while the multiply is running
// 2**CNT_W must exceed MUL_CYCLES.
// -----------------------------------------------------------------------------
module alu_ctl_unit
  import alu_ctl_unit_pkg::*;
#(
  parameter int MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Signal,
  output logic [5:0] SignaltoALU,
  output logic [5:0] SignaltoSHT,
  output logic [5:0] SignaltoMULTU,
  output logic [5:0] SignaltoMUX,
  output logic       busy,
  output logic       done,
  output logic       stall
);

  ctlState_e        state;
  ctlState_e        nextState;
  logic [CNT_W-1:0] mulCnt;
  logic             mulLast;
  logic [5:0]       mulCode;

  // Multiply cycle counter runs exactly while the sequencer sits in MULT
  mul_cycle_counter #(
    .MUL_CYCLES(MUL_CYCLES),
    .CNT_W     (CNT_W)
  ) uMulCounter (
    .clk  (clk),
    .reset(reset),
    .start(state == MULT),
    .cnt  (mulCnt),
    .last (mulLast)
  );

  // Sequencer state register; reset aborts any multiply in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Counter must rest at zero whenever no multiply is running
  always_ff @(posedge clk) begin
    if (!reset && state != MULT) begin
      assert (mulCnt == '0);
    end
  end

  // Next-state and multiplier-side outputs. A MULTU seen while already in
  // MULT is ignored; one seen in DONE chains straight into a new multiply.
  always_comb begin
    nextState = state;
    busy      = 1'b0;
    done      = 1'b0;
    mulCode   = '0;
    case (state)
      IDLE: begin
        if (Signal == FN_MULTU) nextState = MULT;
      end
      MULT: begin
        busy    = 1'b1;
        mulCode = FN_MULTU;
        if (mulLast) nextState = DONE;
      end
      DONE: begin
        done      = 1'b1;
        nextState = (Signal == FN_MULTU) ? MULT : IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Zero-latency funct decode. MFHI/MFLO during a multiply would read stale
  // Hi/Lo, so they stall and the mux select is withheld. Reset silences every
  // unit so nothing downstream acts on a half-decoded instruction.
  always_comb begin
    SignaltoALU   = '0;
    SignaltoSHT   = '0;
    SignaltoMUX   = '0;
    SignaltoMULTU = mulCode;
    stall         = 1'b0;
    if (isAluCode(Signal)) begin
      SignaltoALU = Signal;
      SignaltoMUX = Signal;
    end else if (Signal == FN_SRL) begin
      SignaltoSHT = Signal;
      SignaltoMUX = Signal;
    end else if ((Signal == FN_MFHI) || (Signal == FN_MFLO)) begin
      if (busy) begin
        stall = 1'b1;
      end else begin
        SignaltoMUX = Signal;
      end
    end
    if (reset) begin
      SignaltoALU   = '0;
      SignaltoSHT   = '0;
      SignaltoMUX   = '0;
      SignaltoMULTU = '0;
      stall         = 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_ctl_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_ctl_unit
// Directed bench for alu_ctl_unit. A behavioural model (countdown of remaining
// multiply cycles plus a lookup of funct-code classes) predicts every output
// and is compared against the DUT on each falling edge; literal expectations
// at key points pin both the model and the DUT.
// -----------------------------------------------------------------------------
module tb_alu_ctl_unit;

  localparam int MULC = 32;

  logic       clk;
  logic       reset;
  logic [5:0] Signal;
  logic [5:0] SignaltoALU;
  logic [5:0] SignaltoSHT;
  logic [5:0] SignaltoMULTU;
  logic [5:0] SignaltoMUX;
  logic       busy;
  logic       done;
  logic       stall;

  int checkCount = 0;
  int passCount  = 0;

  // Model state
  int busyLeft      = 0;
  bit inDone        = 0;
  bit prevEdgeReset = 0;

  // Observed timing
  int cycleIdx = 0;
  int curRun   = 0;
  int runLens[$];
  int doneCycles[$];

  alu_ctl_unit #(.MUL_CYCLES(MULC), .CNT_W(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .Signal       (Signal),
    .SignaltoALU  (SignaltoALU),
    .SignaltoSHT  (SignaltoSHT),
    .SignaltoMULTU(SignaltoMULTU),
    .SignaltoMUX  (SignaltoMUX),
    .busy         (busy),
    .done         (done),
    .stall        (stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: every check goes through here
  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cycleIdx, actual, expected);
    end
  endtask

  // Drive inputs, then let the given number of rising edges pass
  task automatic applyStimulus(input logic [5:0] sig, input logic rst, input int cycles);
    Signal = sig;
    reset  = rst;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  function automatic bit modelIsAlu(input int code);
    return code == 32 || code == 34 || code == 36 || code == 37 || code == 42;
  endfunction

  // Model: a multiply is a run of MULC busy cycles followed by one done cycle
  always @(posedge clk) begin
    cycleIdx++;
    if (reset) begin
      busyLeft = 0;
      inDone   = 0;
    end else if (busyLeft > 0) begin
      busyLeft--;
      inDone = (busyLeft == 0);
    end else begin
      inDone = 0;
      if (Signal == 6'd25) busyLeft = MULC;
    end
    prevEdgeReset = reset;
  end

  // Per-cycle comparison against the model, plus run/pulse bookkeeping
  always @(negedge clk) begin
    int sig;
    bit busyE;
    int aluE, shtE, muxE, mulE;
    sig   = int'(Signal);
    busyE = (busyLeft > 0);
    aluE  = modelIsAlu(sig) ? sig : 0;
    shtE  = (sig == 2) ? 2 : 0;
    if (modelIsAlu(sig) || sig == 2) muxE = sig;
    else if (sig == 16 || sig == 18) muxE = busyE ? 0 : sig;
    else muxE = 0;
    mulE = busyE ? 25 : 0;
    if (reset) begin
      aluE = 0; shtE = 0; muxE = 0; mulE = 0;
    end
    checkOutput("alu", int'(SignaltoALU), aluE);
    checkOutput("sht", int'(SignaltoSHT), shtE);
    checkOutput("mux", int'(SignaltoMUX), muxE);
    checkOutput("multu", int'(SignaltoMULTU), mulE);
    if (!reset || prevEdgeReset) begin
      checkOutput("busy", int'(busy), int'(busyE));
      checkOutput("done", int'(done), int'(inDone));
    end
    if (!reset) begin
      checkOutput("stall", int'(stall), int'(busyE && (sig == 16 || sig == 18)));
    end
    if (busy) begin
      curRun++;
    end else if (curRun > 0) begin
      runLens.push_back(curRun);
      curRun = 0;
    end
    if (done) doneCycles.push_back(cycleIdx);
  end

  // Directed sequence with hand-computed expectations
  initial begin
    logic [5:0] sweepCode [8] = '{6'd36, 6'd37, 6'd34, 6'd42, 6'd2, 6'd16, 6'd18, 6'd7};
    int         sweepAlu  [8] = '{36, 37, 34, 42, 0, 0, 0, 0};
    int         sweepSht  [8] = '{0, 0, 0, 0, 2, 0, 0, 0};
    int         sweepMux  [8] = '{36, 37, 34, 42, 2, 16, 18, 0};
    int         doneBefore;

    // Reset held two cycles with ADD presented
    applyStimulus(6'd32, 1'b1, 2);
    checkOutput("rstAlu", int'(SignaltoALU), 0);
    checkOutput("rstMux", int'(SignaltoMUX), 0);
    checkOutput("rstMultu", int'(SignaltoMULTU), 0);
    checkOutput("rstBusy", int'(busy), 0);
    checkOutput("rstDone", int'(done), 0);
    applyStimulus(6'd32, 1'b0, 0);
    checkOutput("postRstAlu", int'(SignaltoALU), 32);
    checkOutput("postRstMux", int'(SignaltoMUX), 32);

    // Decode sweep
    for (int i = 0; i < 8; i++) begin
      applyStimulus(sweepCode[i], 1'b0, 1);
      checkOutput($sformatf("sweepAlu%0d", sweepCode[i]), int'(SignaltoALU), sweepAlu[i]);
      checkOutput($sformatf("sweepSht%0d", sweepCode[i]), int'(SignaltoSHT), sweepSht[i]);
      checkOutput($sformatf("sweepMux%0d", sweepCode[i]), int'(SignaltoMUX), sweepMux[i]);
    end

    // Single MULTU with an MFLO hazard mid-way and another in the done cycle
    applyStimulus(6'd25, 1'b0, 1);
    applyStimulus(6'd32, 1'b0, 9);
    checkOutput("mulAluPass", int'(SignaltoALU), 32);
    checkOutput("mulBusy", int'(busy), 1);
    checkOutput("mulCode", int'(SignaltoMULTU), 25);
    applyStimulus(6'd18, 1'b0, 1);
    checkOutput("hazStall", int'(stall), 1);
    checkOutput("hazMux", int'(SignaltoMUX), 0);
    applyStimulus(6'd32, 1'b0, 21);
    checkOutput("mulBusyLate", int'(busy), 1);
    applyStimulus(6'd18, 1'b0, 1);
    checkOutput("doneHigh", int'(done), 1);
    checkOutput("doneBusy", int'(busy), 0);
    checkOutput("doneStall", int'(stall), 0);
    checkOutput("doneMux", int'(SignaltoMUX), 18);
    applyStimulus(6'd32, 1'b0, 1);
    checkOutput("idleDone", int'(done), 0);
    checkOutput("idleMultu", int'(SignaltoMULTU), 0);
    checkOutput("busyRunLen", (runLens.size() > 0) ? runLens[$] : -1, 32);
    checkOutput("donePulses", doneCycles.size(), 1);

    // MULTU held for 40 cycles: one uninterrupted run, then a chained one
    applyStimulus(6'd25, 1'b0, 40);
    applyStimulus(6'd32, 1'b0, 30);
    checkOutput("reissueDones", doneCycles.size(), 3);
    checkOutput("reissueRun1", (runLens.size() > 1) ? runLens[runLens.size()-2] : -1, 32);
    checkOutput("reissueRun2", (runLens.size() > 0) ? runLens[$] : -1, 32);
    checkOutput("reissueGap",
                (doneCycles.size() == 3) ? doneCycles[2] - doneCycles[1] : -1, 33);

    // Reset in the middle of a multiply
    doneBefore = doneCycles.size();
    applyStimulus(6'd25, 1'b0, 1);
    applyStimulus(6'd32, 1'b0, 14);
    applyStimulus(6'd32, 1'b1, 1);
    checkOutput("abortBusy", int'(busy), 0);
    checkOutput("abortCnt", int'(dut.mulCnt), 0);
    checkOutput("abortMultu", int'(SignaltoMULTU), 0);
    applyStimulus(6'd32, 1'b0, 40);
    checkOutput("abortRunLen", (runLens.size() > 0) ? runLens[$] : -1, 15);
    checkOutput("abortNoDone", doneCycles.size(), doneBefore);

    // Fresh multiply after the abort runs its full length
    applyStimulus(6'd25, 1'b0, 1);
    applyStimulus(6'd32, 1'b0, 34);
    checkOutput("freshRunLen", (runLens.size() > 0) ? runLens[$] : -1, 32);
    checkOutput("freshDone", doneCycles.size(), doneBefore + 1);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/alu_ctl_unit.md
Name: alu_ctl_unit

Overview:
- Function-code control stage that sits directly upstream of the 32-bit ALU, the barrel shifter and the MULTU/HiLo datapath.
- Takes the 6-bit R-type funct code (Signal) and steers it to the correct execution unit.
- Sequences the 32-cycle shift-add MULTU with an internal counter.
- Drives the select code for the output mux (ALU / shifter / Hi / Lo).

Parameters:
- MUL_CYCLES, 32, number of cycles the multiplier is kept enabled after a MULTU is accepted.
- CNT_W, 6, counter width; must satisfy 2^CNT_W > MUL_CYCLES.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- Signal  input  6  funct code from decode: AND 36, OR 37, ADD 32, SUB 34, SLT 42, SRL 2, MULTU 25, MFHI 16, MFLO 18.
- SignaltoALU  output  6  code delivered to the ALU.
- SignaltoSHT  output  6  code delivered to the shifter.
- SignaltoMULTU  output  6  code delivered to the multiplier.
- SignaltoMUX  output  6  select code for the result mux.
- busy  output  1  high while a MULTU is in progress.
- done  output  1  one-cycle pulse when the MULTU result is valid in Hi/Lo.
- stall  output  1  high when an MFHI/MFLO is presented while busy.

Behaviour:
- Reset (reset=1 at a posedge):
  - state=IDLE, cnt=0.
  - busy=0, done=0, stall=0.
  - While reset is high, all four Signalto* outputs are forced to 0, regardless of Signal.
- Pass-through decode (combinational from Signal, zero latency):
  - ALU codes (32/34/36/37/42): SignaltoALU=Signal; SignaltoSHT=0; SignaltoMUX=Signal.
  - SRL (2): SignaltoSHT=2; SignaltoALU=0; SignaltoMUX=2.
  - MFHI (16) / MFLO (18): SignaltoMUX=Signal; SignaltoALU=0; SignaltoSHT=0.
  - Any other code: SignaltoALU=0, SignaltoSHT=0, SignaltoMUX=0.
- FSM states IDLE, MULT, DONE:
  - IDLE: Signal==25 at a posedge -> MULT with cnt=0. Otherwise stay.
  - MULT: cnt increments every cycle. When cnt==MUL_CYCLES-1 -> DONE. busy=1 throughout. SignaltoMULTU=25 throughout, independent of the current Signal.
  - DONE: lasts exactly one cycle. done=1, busy=0, SignaltoMULTU=0. Next state is IDLE; if Signal==25 in DONE, the next state is MULT and a new multiply starts (back-to-back allowed).
  - SignaltoMULTU is 0 in IDLE.
- Latency: the MULTU is accepted at edge E0, busy rises after E0, and done is high during the cycle after edge E0+MUL_CYCLES.
- While busy:
  - A new MULTU is ignored; it does not restart or extend the counter.
  - ALU and SRL codes still pass through normally.
  - MFHI/MFLO assert stall=1 (combinational) and force SignaltoMUX=0, so that stale Hi/Lo is never selected.
- Counter:
  - Unsigned CNT_W bits, counts 0..MUL_CYCLES-1.
  - Never wraps, because the FSM leaves MULT at the terminal count.
  - Held at 0 outside MULT.
- Reset mid-multiply: abort the operation. State returns to IDLE next cycle, no done pulse, and the multiplier sees SignaltoMULTU=0.

Decomposition:
- Shared package/header (also used by the ALU, shifter and MULTU blocks):
  - Funct-code constants: AND, OR, ADD, SUB, SLT, SRL, MULTU, MFHI, MFLO.
  - FSM state encoding.
  - MUL_CYCLES default.
- One natural sub-module: mul_cycle_counter, holding the counter plus terminal-count flag, with inputs clk, reset, start and outputs cnt, last.
- Decode and FSM stay in the top level.

Test Plan:
- Reset: assert reset 2 cycles with Signal=32 -> all Signalto*=0, busy=0, done=0. Deassert -> SignaltoALU=32 and SignaltoMUX=32 in the same cycle.
- Decode sweep: Signal=36, 37, 34, 42, 2, 16, 18, 7 in turn -> ALU codes appear on SignaltoALU/MUX; SRL gives SignaltoSHT=2 and MUX=2; MFHI/MFLO give MUX=16/18; code 7 gives all outputs 0.
- MULTU timing: Signal=25 for one cycle, then 32 -> busy high for exactly 32 cycles, SignaltoMULTU=25 throughout, done high for exactly 1 cycle, then IDLE. ADD stays visible on SignaltoALU during busy.
- Hazard: issue MFLO (18) at cycle 10 of a multiply -> stall=1 and SignaltoMUX=0. Issue MFLO in the DONE cycle -> stall=0 and SignaltoMUX=18.
- Re-issue: MULTU held high for 40 cycles -> first multiply runs 32 cycles and is not restarted by the repeated 25; a second multiply starts from DONE, giving a 2nd done pulse 33 cycles after the first.
- Reset mid-op: assert reset at multiply cycle 15 -> busy=0 the next cycle, no done pulse, cnt=0. A fresh MULTU afterwards completes after a full 32 cycles.
